cache_write_interface: RTL and testbench

// Write-side counterpart of the cache read streamer. Accepts transfer descriptors and a stream of IWIDTH-bit data beats

---
 rtl/cache_write_interface.sv | 145 ++++++++++++++
 tb/tb_cache_write_interface.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_write_interface.sv
// Splits IWIDTH-bit stream beats into CWIDTH-bit words and writes them into the cache SRAM, wrapping within a line.
// Optional byte-mask support is compiled in with the CWI_WMASK_EN macro.
module cache_write_interface #(
    parameter int ADDR_BITS = 10,
    parameter int LEN_BITS  = 8,
    parameter int IWIDTH    = 128,
    parameter int CWIDTH    = 32,
    parameter int LINE_BITS = 5,
    parameter int ID_LEN    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 OUT_ready,
    input  logic                 IN_valid,
    input  logic [ID_LEN-1:0]    IN_id,
    input  logic [ADDR_BITS-1:0] IN_addr,
    input  logic [LEN_BITS-1:0]  IN_len,
    output logic                 OUT_dataReady,
    input  logic                 IN_dataValid,
    input  logic [IWIDTH-1:0]    IN_data,
`ifdef CWI_WMASK_EN
    input  logic [IWIDTH/8-1:0]  IN_wmask,
    output logic [CWIDTH/8-1:0]  OUT_CACHE_wm,
`endif
    input  logic                 IN_CACHE_ready,
    output logic                 OUT_CACHE_ce,
    output logic                 OUT_CACHE_we,
    output logic [ADDR_BITS-1:0] OUT_CACHE_addr,
    output logic [CWIDTH-1:0]    OUT_CACHE_data,
    output logic                 OUT_cacheWriteValid,
    output logic [ID_LEN-1:0]    OUT_cacheWriteId,
    output logic                 OUT_doneValid,
    output logic [ID_LEN-1:0]    OUT_doneId
);
    localparam int WPB   = IWIDTH / CWIDTH;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int STEP  = CWIDTH / 32;
    localparam int SHIFT = $clog2(STEP);

    logic                 cur_valid, next_valid;
    logic [ID_LEN-1:0]    cur_id, next_id;
    logic [ADDR_BITS-1:0] cur_addr, next_addr;
    logic [LEN_BITS-1:0]  cur_len, next_len;
    logic                 beat_valid;
    logic [IWIDTH-1:0]    beat_data;
    logic [IDX_W-1:0]     idx;
    logic [LEN_BITS-1:0]  progress;
    logic                 done_valid;
    logic [ID_LEN-1:0]    done_id;

    logic                 attempt, skip, commit, last_word, last_in_beat;
    logic                 retire, beat_free, desc_acc, beat_acc;
    logic [LINE_BITS-1:0] line_off;

`ifdef CWI_WMASK_EN
    logic [IWIDTH/8-1:0]  beat_mask;
    logic [CWIDTH/8-1:0]  word_mask;

    assign word_mask    = beat_mask[idx*(CWIDTH/8) +: CWIDTH/8];
    // Fully masked words are consumed locally without touching the SRAM.
    assign skip         = (word_mask == '0);
    assign OUT_CACHE_wm = word_mask;
`else
    assign skip = 1'b0;
`endif

    assign attempt      = cur_valid && beat_valid;
    assign commit       = attempt && (IN_CACHE_ready || skip);
    assign last_word    = (progress >> SHIFT) == (cur_len >> SHIFT);
    assign last_in_beat = (idx == IDX_W'(WPB - 1));
    assign retire       = commit && last_word;
    assign beat_free    = commit && (last_in_beat || last_word);

    assign OUT_ready     = !next_valid || retire;
    assign OUT_dataReady = !beat_valid || beat_free;
    assign desc_acc      = IN_valid && OUT_ready;
    assign beat_acc      = IN_dataValid && OUT_dataReady;

    assign line_off            = cur_addr[LINE_BITS-1:0] + progress[LINE_BITS-1:0];
    assign OUT_CACHE_ce        = !(attempt && !skip);
    assign OUT_CACHE_we        = !(attempt && !skip);
    assign OUT_CACHE_addr      = {cur_addr[ADDR_BITS-1:LINE_BITS], line_off};
    assign OUT_CACHE_data      = beat_data[idx*CWIDTH +: CWIDTH];
    assign OUT_cacheWriteValid = commit && !skip;
    assign OUT_cacheWriteId    = cur_id;
    assign OUT_doneValid       = done_valid;
    assign OUT_doneId          = done_id;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_valid  <= 1'b0;
            next_valid <= 1'b0;
            beat_valid <= 1'b0;
            idx        <= '0;
            progress   <= '0;
            done_valid <= 1'b0;
        end else begin
            // Descriptor queue: an incoming descriptor lands in cur when cur frees up, else in next.
            if (!cur_valid || retire) begin
                if (next_valid) begin
                    cur_id     <= next_id;
                    cur_addr   <= next_addr;
                    cur_len    <= next_len;
                    next_valid <= desc_acc;
                    next_id    <= IN_id;
                    next_addr  <= IN_addr;
                    next_len   <= IN_len;
                end else begin
                    cur_valid <= desc_acc;
                    cur_id    <= IN_id;
                    cur_addr  <= IN_addr;
                    cur_len   <= IN_len;
                end
            end else if (desc_acc) begin
                next_valid <= 1'b1;
                next_id    <= IN_id;
                next_addr  <= IN_addr;
                next_len   <= IN_len;
            end

            if (retire)
                progress <= '0;
            else if (commit)
                progress <= progress + LEN_BITS'(STEP);

            // A final beat is dropped on retire even if words remain.
            if (beat_acc) begin
                beat_valid <= 1'b1;
                beat_data  <= IN_data;
`ifdef CWI_WMASK_EN
                beat_mask  <= IN_wmask;
`endif
                idx        <= '0;
            end else if (beat_free) begin
                beat_valid <= 1'b0;
                idx        <= '0;
            end else if (commit) begin
                idx <= idx + 1'b1;
            end

            done_valid <= retire;
            done_id    <= cur_id;
        end
    end
endmodule

// File: tb/tb_cache_write_interface.sv
// Randomized and directed bench for cache_write_interface against a word-list reference model.
module tb_cache_write_interface;
    localparam int ADDR_BITS = 10, LEN_BITS = 8, IWIDTH = 128, CWIDTH = 32, LINE_BITS = 5, ID_LEN = 2;
    localparam int WPB = IWIDTH / CWIDTH;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 OUT_ready;
    logic                 IN_valid = 1'b0;
    logic [ID_LEN-1:0]    IN_id = '0;
    logic [ADDR_BITS-1:0] IN_addr = '0;
    logic [LEN_BITS-1:0]  IN_len = '0;
    logic                 OUT_dataReady;
    logic                 IN_dataValid = 1'b0;
    logic [IWIDTH-1:0]    IN_data = '0;
    logic                 IN_CACHE_ready = 1'b1;
    logic                 OUT_CACHE_ce, OUT_CACHE_we;
    logic [ADDR_BITS-1:0] OUT_CACHE_addr;
    logic [CWIDTH-1:0]    OUT_CACHE_data;
    logic                 OUT_cacheWriteValid;
    logic [ID_LEN-1:0]    OUT_cacheWriteId;
    logic                 OUT_doneValid;
    logic [ID_LEN-1:0]    OUT_doneId;
    logic [CWIDTH/8-1:0]  wm_obs;
`ifdef CWI_WMASK_EN
    logic [IWIDTH/8-1:0]  IN_wmask = '1;
    logic [CWIDTH/8-1:0]  OUT_CACHE_wm;
    assign wm_obs = OUT_CACHE_wm;
`else
    assign wm_obs = '1;
`endif

    always #5 clk = ~clk;

    cache_write_interface #(
        .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS), .IWIDTH(IWIDTH),
        .CWIDTH(CWIDTH), .LINE_BITS(LINE_BITS), .ID_LEN(ID_LEN)
    ) dut (
        .clk(clk), .rst(rst),
        .OUT_ready(OUT_ready), .IN_valid(IN_valid), .IN_id(IN_id), .IN_addr(IN_addr), .IN_len(IN_len),
        .OUT_dataReady(OUT_dataReady), .IN_dataValid(IN_dataValid), .IN_data(IN_data),
`ifdef CWI_WMASK_EN
        .IN_wmask(IN_wmask), .OUT_CACHE_wm(OUT_CACHE_wm),
`endif
        .IN_CACHE_ready(IN_CACHE_ready), .OUT_CACHE_ce(OUT_CACHE_ce), .OUT_CACHE_we(OUT_CACHE_we),
        .OUT_CACHE_addr(OUT_CACHE_addr), .OUT_CACHE_data(OUT_CACHE_data),
        .OUT_cacheWriteValid(OUT_cacheWriteValid), .OUT_cacheWriteId(OUT_cacheWriteId),
        .OUT_doneValid(OUT_doneValid), .OUT_doneId(OUT_doneId)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int rdy_lo = 0;
    int rdy_hi = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready for the upcoming cycle (cyc+1): 0 = always, 1 = random, 2 = low inside [rdy_lo, rdy_hi].
    always @(posedge clk)
        case (rdy_mode)
            0:       IN_CACHE_ready <= 1'b1;
            1:       IN_CACHE_ready <= ($urandom_range(0, 3) != 0);
            default: IN_CACHE_ready <= !((cyc + 1) >= rdy_lo && (cyc + 1) <= rdy_hi);
        endcase

    typedef struct {
        int                   c;
        logic [ADDR_BITS-1:0] a;
        logic [CWIDTH-1:0]    d;
        logic [ID_LEN-1:0]    id;
        logic                 dr;
    } wr_t;
    typedef struct {
        int                   c;
        logic                 ce;
        logic [ADDR_BITS-1:0] a;
        logic [CWIDTH-1:0]    d;
        logic [CWIDTH/8-1:0]  wm;
    } tr_t;

    wr_t                  obs_w[$];
    wr_t                  exp_w[$];
    tr_t                  tr[$];
    int                   done_c[$];
    logic [ID_LEN-1:0]    done_id[$];
    logic [ID_LEN-1:0]    dq_id[$];
    logic [ADDR_BITS-1:0] dq_addr[$];
    logic [LEN_BITS-1:0]  dq_len[$];
    logic [IWIDTH-1:0]    bq_data[$];
    logic [IWIDTH/8-1:0]  bq_mask[$];

    always @(negedge clk) begin
        tr.push_back('{cyc, OUT_CACHE_ce, OUT_CACHE_addr, OUT_CACHE_data, wm_obs});
        if (OUT_cacheWriteValid === 1'b1)
            obs_w.push_back('{cyc, OUT_CACHE_addr, OUT_CACHE_data, OUT_cacheWriteId, OUT_dataReady});
        if (OUT_doneValid === 1'b1) begin
            done_c.push_back(cyc);
            done_id.push_back(OUT_doneId);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    function automatic logic [IWIDTH-1:0] rand_beat();
        logic [IWIDTH-1:0] b;
        for (int i = 0; i < IWIDTH / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic void clear_obs();
        obs_w.delete(); exp_w.delete(); tr.delete(); done_c.delete(); done_id.delete();
        dq_id.delete(); dq_addr.delete(); dq_len.delete(); bq_data.delete(); bq_mask.delete();
    endfunction

    function automatic void add_desc(input logic [ID_LEN-1:0] id, input logic [ADDR_BITS-1:0] a,
                                     input logic [LEN_BITS-1:0] l, input bit with_beats);
        dq_id.push_back(id); dq_addr.push_back(a); dq_len.push_back(l);
        if (with_beats)
            for (int i = 0; i < (int'(l) + WPB) / WPB; i++) begin
                bq_data.push_back(rand_beat());
                bq_mask.push_back('1);
            end
    endfunction

    // Reference: transfer i writes word k of its own beat run to line-wrapped address start+k.
    function automatic void build_expected();
        int                   base;
        int                   n;
        wr_t                  w;
        logic [IWIDTH-1:0]    b;
        logic [LINE_BITS-1:0] off;
        base = 0;
        exp_w.delete();
        for (int i = 0; i < dq_id.size(); i++) begin
            n = int'(dq_len[i]) + 1;
            for (int k = 0; k < n; k++) begin
                b    = bq_data[base + k / WPB];
                off  = dq_addr[i][LINE_BITS-1:0] + LINE_BITS'(k);
                w.c  = 0;
                w.a  = {dq_addr[i][ADDR_BITS-1:LINE_BITS], off};
                w.d  = b[(k % WPB) * CWIDTH +: CWIDTH];
                w.id = dq_id[i];
                w.dr = 1'b0;
                exp_w.push_back(w);
            end
            base += (n + WPB - 1) / WPB;
        end
    endfunction

    // Senders assume they start just after a rising edge.
    task automatic send_descs(input bit gaps);
        int t;
        for (int i = 0; i < dq_id.size(); i++) begin
            t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                IN_valid = 1'b0;
                @(posedge clk); #1;
            end
            IN_valid = 1'b1; IN_id = dq_id[i]; IN_addr = dq_addr[i]; IN_len = dq_len[i];
            @(negedge clk);
            while (OUT_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
            total++;
            if (t >= 2000) begin bad++; $display("FAIL desc_handshake: OUT_ready=%b required 1 within 2000 cycles", OUT_ready); end
            @(posedge clk); #1;
        end
        IN_valid = 1'b0;
    endtask

    task automatic send_beats(input bit gaps);
        int t;
        for (int i = 0; i < bq_data.size(); i++) begin
            t = 0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                IN_dataValid = 1'b0;
                @(posedge clk); #1;
            end
            IN_dataValid = 1'b1; IN_data = bq_data[i];
`ifdef CWI_WMASK_EN
            IN_wmask = bq_mask[i];
`endif
            @(negedge clk);
            while (OUT_dataReady !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
            total++;
            if (t >= 2000) begin bad++; $display("FAIL beat_handshake: OUT_dataReady=%b required 1 within 2000 cycles", OUT_dataReady); end
            @(posedge clk); #1;
        end
        IN_dataValid = 1'b0;
    endtask

    task automatic wait_done(input int nd, input int budget);
        int t;
        t = 0;
        while (done_id.size() < nd && t < budget) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [IWIDTH-1:0] b;
        int r;
        b = rand_beat();
        rst = 1'b0; IN_valid = 1'b1; IN_id = 2'd2; IN_addr = 10'h155; IN_len = 8'd0;
        IN_dataValid = 1'b1; IN_data = b;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            total++;
            if ({OUT_CACHE_ce, OUT_CACHE_we, OUT_ready, OUT_dataReady, OUT_cacheWriteValid, OUT_doneValid} !== 6'b111100) begin
                bad++;
                $display("FAIL reset_outputs: ce/we/rdy/drdy/wv/dv=%b%b%b%b%b%b required 111100", OUT_CACHE_ce, OUT_CACHE_we,
                         OUT_ready, OUT_dataReady, OUT_cacheWriteValid, OUT_doneValid);
            end
        end
        @(posedge clk); #1;
        total++;
        if (obs_w.size() != 0) begin bad++; $display("FAIL reset_no_commit: commits=%0d required 0", obs_w.size()); end
        rst = 1'b1;
        r = cyc;
        @(posedge clk); #1;
        IN_valid = 1'b0; IN_dataValid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (obs_w.size() != 1) begin
            bad++; $display("FAIL reset_first_write_count: got %0d required 1", obs_w.size());
        end else begin
            total++;
            if (obs_w[0].c != r + 1 || obs_w[0].a !== 10'h155 || obs_w[0].d !== b[CWIDTH-1:0] || obs_w[0].id !== 2'd2) begin
                bad++;
                $display("FAIL reset_first_write: cyc=%0d a=%h d=%h id=%0d required cyc=%0d a=155 d=%h id=2",
                         obs_w[0].c, obs_w[0].a, obs_w[0].d, obs_w[0].id, r + 1, b[CWIDTH-1:0]);
            end
        end
        total++;
        if (done_c.size() != 1 || done_c[0] != r + 2 || done_id[0] !== 2'd2) begin
            bad++; $display("FAIL reset_done: count=%0d required 1 at cyc %0d id 2", done_c.size(), r + 2);
        end
    endtask

    task automatic test_wrap();
        int c0;
        clear_obs(); rdy_mode = 0;
        add_desc(2'd1, 10'h01C, 8'd7, 1'b1);
        build_expected();
        @(posedge clk); #1; c0 = cyc;
        fork send_descs(1'b0); send_beats(1'b0); join
        wait_done(1, 200);
        total++;
        if (obs_w.size() != 8) begin bad++; $display("FAIL wrap_count: got %0d required 8", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            total++;
            if (obs_w[i].a !== exp_w[i].a || obs_w[i].d !== exp_w[i].d || obs_w[i].id !== exp_w[i].id || obs_w[i].c != c0 + 1 + i) begin
                bad++;
                $display("FAIL wrap_word%0d: cyc=%0d a=%h d=%h id=%0d required cyc=%0d a=%h d=%h id=%0d", i, obs_w[i].c,
                         obs_w[i].a, obs_w[i].d, obs_w[i].id, c0 + 1 + i, exp_w[i].a, exp_w[i].d, exp_w[i].id);
            end
        end
        total++;
        if (done_c.size() != 1 || done_c[0] != c0 + 9 || done_id[0] !== 2'd1) begin
            bad++; $display("FAIL wrap_done: count=%0d required 1 at cyc %0d id 1", done_c.size(), c0 + 9);
        end
    endtask

    task automatic test_backpressure();
        int c0;
        int f;
        int want[4];
        clear_obs();
        add_desc(2'd2, 10'h040, 8'd3, 1'b1);
        build_expected();
        @(posedge clk); #1; c0 = cyc; f = c0 + 1;
        rdy_lo = f + 1; rdy_hi = f + 3; rdy_mode = 2;
        fork send_descs(1'b0); send_beats(1'b0); join
        wait_done(1, 200);
        rdy_mode = 0;
        want = '{f, f + 4, f + 5, f + 6};
        total++;
        if (obs_w.size() != 4) begin bad++; $display("FAIL bp_count: got %0d required 4", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < 4; i++) begin
            total++;
            if (obs_w[i].a !== exp_w[i].a || obs_w[i].d !== exp_w[i].d || obs_w[i].c != want[i]) begin
                bad++;
                $display("FAIL bp_word%0d: cyc=%0d a=%h d=%h required cyc=%0d a=%h d=%h", i, obs_w[i].c, obs_w[i].a,
                         obs_w[i].d, want[i], exp_w[i].a, exp_w[i].d);
            end
        end
        foreach (tr[i])
            if (tr[i].c >= f + 1 && tr[i].c <= f + 3) begin
                total++;
                if (tr[i].ce !== 1'b0 || tr[i].a !== exp_w[1].a || tr[i].d !== exp_w[1].d) begin
                    bad++;
                    $display("FAIL bp_hold cyc%0d: ce=%b a=%h d=%h required ce=0 a=%h d=%h", tr[i].c, tr[i].ce, tr[i].a,
                             tr[i].d, exp_w[1].a, exp_w[1].d);
                end
            end
    endtask

    task automatic test_partial();
        clear_obs(); rdy_mode = 0;
        add_desc(2'd3, 10'h100, 8'd1, 1'b1);
        add_desc(2'd0, 10'h2A6, 8'd0, 1'b1);
        build_expected();
        @(posedge clk); #1;
        fork send_descs(1'b0); send_beats(1'b0); join
        wait_done(2, 200);
        total++;
        if (obs_w.size() != 3) begin bad++; $display("FAIL partial_count: got %0d required 3", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            total++;
            if (obs_w[i].a !== exp_w[i].a || obs_w[i].d !== exp_w[i].d || obs_w[i].id !== exp_w[i].id) begin
                bad++;
                $display("FAIL partial_word%0d: a=%h d=%h id=%0d required a=%h d=%h id=%0d", i, obs_w[i].a, obs_w[i].d,
                         obs_w[i].id, exp_w[i].a, exp_w[i].d, exp_w[i].id);
            end
        end
        if (obs_w.size() >= 2) begin
            total++;
            if (obs_w[0].dr !== 1'b0 || obs_w[1].dr !== 1'b1) begin
                bad++; $display("FAIL partial_dataready: commit1=%b commit2=%b required 0 1", obs_w[0].dr, obs_w[1].dr);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [ADDR_BITS-1:0] a;
        clear_obs(); rdy_mode = 0;
        a = ADDR_BITS'($urandom);
        add_desc(2'd0, a, 8'd3, 1'b1);
        add_desc(2'd1, a + 10'd40, 8'd3, 1'b1);
        build_expected();
        @(posedge clk); #1; c0 = cyc;
        fork send_descs(1'b0); send_beats(1'b0); join
        wait_done(2, 200);
        total++;
        if (obs_w.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d required 8", obs_w.size()); end
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            total++;
            if (obs_w[i].a !== exp_w[i].a || obs_w[i].d !== exp_w[i].d || obs_w[i].id !== exp_w[i].id || obs_w[i].c != c0 + 1 + i) begin
                bad++;
                $display("FAIL b2b_word%0d: cyc=%0d a=%h d=%h id=%0d required cyc=%0d a=%h d=%h id=%0d", i, obs_w[i].c,
                         obs_w[i].a, obs_w[i].d, obs_w[i].id, c0 + 1 + i, exp_w[i].a, exp_w[i].d, exp_w[i].id);
            end
        end
        total++;
        if (done_id.size() != 2 || done_id[0] !== 2'd0 || done_id[1] !== 2'd1 || done_c[0] != c0 + 5 || done_c[1] != c0 + 9) begin
            bad++; $display("FAIL b2b_done: count=%0d required ids 0,1 at cyc %0d,%0d", done_id.size(), c0 + 5, c0 + 9);
        end
    endtask

    task automatic test_random();
        int nd;
        for (int r = 0; r < 12; r++) begin
            clear_obs(); rdy_mode = 1;
            nd = $urandom_range(1, 5);
            for (int i = 0; i < nd; i++)
                add_desc(ID_LEN'($urandom), ADDR_BITS'($urandom),
                         ($urandom_range(0, 4) == 0) ? LEN_BITS'($urandom_range(12, 40)) : LEN_BITS'($urandom_range(0, 11)), 1'b1);
            build_expected();
            @(posedge clk); #1;
            fork send_descs(1'b1); send_beats(1'b1); join
            wait_done(nd, 3000);
            total++;
            if (obs_w.size() != exp_w.size() || done_id.size() != nd) begin
                bad++;
                $display("FAIL rand%0d_count: writes=%0d dones=%0d required %0d %0d", r, obs_w.size(), done_id.size(),
                         exp_w.size(), nd);
            end
            for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
                total++;
                if (obs_w[i].a !== exp_w[i].a || obs_w[i].d !== exp_w[i].d || obs_w[i].id !== exp_w[i].id) begin
                    bad++;
                    $display("FAIL rand%0d_word%0d: a=%h d=%h id=%0d required a=%h d=%h id=%0d", r, i, obs_w[i].a,
                             obs_w[i].d, obs_w[i].id, exp_w[i].a, exp_w[i].d, exp_w[i].id);
                end
            end
            for (int i = 0; i < done_id.size() && i < nd; i++) begin
                total++;
                if (done_id[i] !== dq_id[i]) begin
                    bad++; $display("FAIL rand%0d_done%0d: id=%0d required %0d", r, i, done_id[i], dq_id[i]);
                end
            end
        end
        rdy_mode = 0;
    endtask

`ifdef CWI_WMASK_EN
    task automatic test_wmask();
        int c0;
        clear_obs(); rdy_mode = 0;
        add_desc(2'd1, 10'h080, 8'd3, 1'b1);
        bq_mask[0] = 16'h00F0;
        @(posedge clk); #1; c0 = cyc;
        fork send_descs(1'b0); send_beats(1'b0); join
        wait_done(1, 200);
        total++;
        if (obs_w.size() != 1 || obs_w[0].a !== 10'h081 || obs_w[0].d !== bq_data[0][2*CWIDTH-1:CWIDTH]) begin
            bad++; $display("FAIL wmask_write: count=%0d required 1 write to 081", obs_w.size());
        end
        foreach (tr[i])
            if (tr[i].c >= c0 + 1 && tr[i].c <= c0 + 4) begin
                total++;
                if (tr[i].ce !== (tr[i].c != c0 + 2) || (tr[i].c == c0 + 2 && tr[i].wm !== 4'hF)) begin
                    bad++; $display("FAIL wmask_cyc%0d: ce=%b wm=%h required ce=%b", tr[i].c, tr[i].ce, tr[i].wm, tr[i].c != c0 + 2);
                end
            end
        total++;
        if (done_c.size() != 1 || done_c[0] != c0 + 5) begin
            bad++; $display("FAIL wmask_done: count=%0d required 1 at cyc %0d", done_c.size(), c0 + 5);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap();
        test_backpressure();
        test_partial();
        test_back_to_back();
        test_random();
`ifdef CWI_WMASK_EN
        test_wmask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
